// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position, data enable and lock status from a VGA HS/VS stream.
// Optional ERR_CNT output (saturating loss-of-lock counter) is enabled by VGA_DEC_ERR_CNT_EN.
module vga_sync_decoder #(
  parameter int H_VIS      = 640,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_TOTAL    = 800,
  parameter int V_VIS      = 480,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_LINES = 4
) (
  input  logic        PIX_CLK,
  input  logic        RST_N,
  input  logic        HS,
  input  logic        VS,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic        DE,
  output logic        LOCKED,
  output logic [10:0] LINE_LEN,
  output logic        ERR
`ifdef VGA_DEC_ERR_CNT_EN
  ,
  output logic [7:0]  ERR_CNT
`endif
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, HLOCK} hstate_e;

  localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
  localparam logic [10:0] H_START_L = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_L   = 11'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0]  V_START_L = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END_L   = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [7:0]  GOOD_LAST = 8'(LOCK_LINES - 1);

  hstate_e     state_q, state_d;
  logic        hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
  logic [10:0] h_cnt_q, h_cnt_d, len_q, len_d;
  logic [9:0]  v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
  logic [7:0]  good_q, good_d;
  logic        len_vld_q, len_vld_d, vs_pend_q, vs_pend_d;
  logic        vs_seen_q, vs_seen_d, vlock_q, vlock_d;
  logic        de_q, de_d, err_q, err_d;

  logic        hs_fall, vs_fall, frame_restart, vs_ok, h_timeout, len_good;
  logic        locked_now, locked_d, h_vis, v_vis;
  logic [10:0] h_inc;

  always_comb begin
    hs_fall       = hs_dly_q & ~HS;
    vs_fall       = vs_dly_q & ~VS;
    // A VS edge may land mid-line; the frame restarts on the next HS edge.
    frame_restart = hs_fall & (vs_fall | vs_pend_q);
    h_inc         = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
    len_good      = (h_inc == H_TOTAL_L);
    h_timeout     = ~hs_fall & (h_cnt_q == H_TOTAL_L - 11'd1);
    vs_ok         = ({1'b0, v_cnt_q} + 11'd1 == 11'(V_TOTAL));
    locked_now    = (state_q == HLOCK) & vlock_q;
    err_d         = locked_now & ((hs_fall & ~len_good) | h_timeout |
                                  (frame_restart & vs_seen_q & ~vs_ok));

    hs_dly_d  = HS;
    vs_dly_d  = VS;
    h_cnt_d   = hs_fall ? 11'd0 : h_inc;
    len_d     = len_q;
    len_vld_d = len_vld_q | hs_fall;
    if (hs_fall && len_vld_q) len_d = h_inc;

    v_cnt_d   = v_cnt_q;
    vs_pend_d = vs_pend_q | vs_fall;
    vs_seen_d = vs_seen_q | frame_restart;
    vlock_d   = vlock_q;
    if (hs_fall) begin
      vs_pend_d = 1'b0;
      v_cnt_d   = frame_restart ? 10'd0 : v_cnt_q + 10'd1;
    end
    if (frame_restart) vlock_d = vs_seen_q & vs_ok;

    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (hs_fall) begin
          state_d = ACQUIRE;
          good_d  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (hs_fall) begin
          if (!len_good) begin
            good_d = 8'd0;
          end else if (good_q == GOOD_LAST) begin
            state_d = HLOCK;
            good_d  = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      HLOCK: begin
        // Horizontal timing breaking drops lock even before vertical lock exists.
        if ((hs_fall && !len_good) || h_timeout) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    if (err_d) begin
      state_d = SEARCH;
      good_d  = 8'd0;
      vlock_d = 1'b0;
    end

    locked_d = (state_d == HLOCK) & vlock_d;
    h_vis    = (h_cnt_q >= H_START_L) & (h_cnt_q < H_END_L);
    v_vis    = (v_cnt_q >= V_START_L) & (v_cnt_q < V_END_L);
    de_d     = locked_d & h_vis & v_vis;
    x_d      = de_d ? 10'(h_cnt_q - H_START_L) : 10'd0;
    y_d      = de_d ? (v_cnt_q - V_START_L) : 10'd0;
  end

  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= SEARCH;
      hs_dly_q  <= 1'b1;
      vs_dly_q  <= 1'b1;
      h_cnt_q   <= 11'd0;
      len_q     <= 11'd0;
      len_vld_q <= 1'b0;
      v_cnt_q   <= 10'd0;
      vs_pend_q <= 1'b0;
      vs_seen_q <= 1'b0;
      vlock_q   <= 1'b0;
      good_q    <= 8'd0;
      de_q      <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      h_cnt_q   <= h_cnt_d;
      len_q     <= len_d;
      len_vld_q <= len_vld_d;
      v_cnt_q   <= v_cnt_d;
      vs_pend_q <= vs_pend_d;
      vs_seen_q <= vs_seen_d;
      vlock_q   <= vlock_d;
      good_q    <= good_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      err_q     <= err_d;
    end
  end

  assign X        = x_q;
  assign Y        = y_q;
  assign DE       = de_q;
  assign LOCKED   = locked_now;
  assign LINE_LEN = len_q;
  assign ERR      = err_q;

`ifdef VGA_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 8x4 visible raster (16 clk lines, 10 line frames).
// Line-segment tables drive the stream; mid-line reset, HS stall and error counting are hand sequences.
module tb_vga_sync_decoder;

  localparam int H_VIS = 8, H_SYNC = 2, H_BP = 2, H_TOTAL = 16;
  localparam int V_VIS = 4, V_SYNC = 1, V_BP = 2, V_TOTAL = 10, LOCK_LINES = 4;
  localparam int HSB = H_SYNC + H_BP;
  localparam int VSB = V_SYNC + V_BP;

  logic        pix_clk, rst_n, hs, vs_in;
  logic [9:0]  x, y;
  logic        de, locked, err;
  logic [10:0] line_len;
`ifdef VGA_DEC_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  vga_sync_decoder #(
    .H_VIS(H_VIS), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_VIS(V_VIS), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .LOCK_LINES(LOCK_LINES)
  ) dut (
    .PIX_CLK (pix_clk),
    .RST_N   (rst_n),
    .HS      (hs),
    .VS      (vs_in),
    .X       (x),
    .Y       (y),
    .DE      (de),
    .LOCKED  (locked),
    .LINE_LEN(line_len),
    .ERR     (err)
`ifdef VGA_DEC_ERR_CNT_EN
    ,
    .ERR_CNT (err_cnt)
`endif
  );

  // clock / reset
  initial begin
    pix_clk = 1'b0;
    forever #5 pix_clk = ~pix_clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n;        // number of lines in this segment
    int len;      // clocks per line
    bit vs;       // VS low during the first line of the segment
    int exp_len;  // LINE_LEN right after each line's HS edge
    bit exp_lock; // LOCKED throughout each line
    bit exp_err;  // ERR right after each line's HS edge
  } seg_t;

  int          checks = 0;
  int          errors = 0;
  int          fl = 0;
  int          gl = 0;
  logic [19:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  // driver: one HS line; VS low for the whole line when vs_low is set
  task automatic run_line(input int len, input bit vs_low, input int exp_len,
                          input bit exp_lock, input bit exp_err, input bit do_chk);
    bit          exp_de;
    logic [19:0] px;
    if (vs_low) fl = 0;
    else        fl++;
    for (int c = 0; c < len; c++) begin
      hs    = (c < H_SYNC) ? 1'b0 : 1'b1;
      vs_in = vs_low ? 1'b0 : 1'b1;
      tick();
      if (do_chk) begin
        if (c == 0) begin
          chk($sformatf("g%0d LINE_LEN", gl), int'(line_len), exp_len);
          chk($sformatf("g%0d ERR at edge", gl), int'(err), int'(exp_err));
        end else begin
          chk($sformatf("g%0d c%0d ERR", gl, c), int'(err), 0);
        end
        chk($sformatf("g%0d c%0d LOCKED", gl, c), int'(locked), int'(exp_lock));
        exp_de = exp_lock && (c >= HSB + 1) && (c <= HSB + H_VIS) &&
                 (fl >= VSB) && (fl < VSB + V_VIS);
        if (exp_de) exp_q.push_back({10'(fl - VSB), 10'(c - HSB - 1)});
        chk($sformatf("g%0d c%0d DE", gl, c), int'(de), int'(exp_de));
        if (de) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("g%0d c%0d unexpected pixel", gl, c), 1, 0);
          end else begin
            px = exp_q.pop_front();
            chk($sformatf("g%0d c%0d X", gl, c), int'(x), int'(px[9:0]));
            chk($sformatf("g%0d c%0d Y", gl, c), int'(y), int'(px[19:10]));
          end
        end else begin
          chk($sformatf("g%0d c%0d X idle", gl, c), int'(x), 0);
          chk($sformatf("g%0d c%0d Y idle", gl, c), int'(y), 0);
        end
      end
    end
    gl++;
  endtask

  task automatic apply_seg(input seg_t s);
    for (int i = 0; i < s.n; i++)
      run_line(s.len, s.vs && (i == 0), s.exp_len, s.exp_lock, s.exp_err, 1'b1);
  endtask

  seg_t main_tbl[15];
  seg_t rst_tbl[6];

  initial begin
    main_tbl[0]  = '{1, 16, 1'b1,  0, 1'b0, 1'b0}; // first edge: SEARCH->ACQUIRE, no length yet
    main_tbl[1]  = '{9, 16, 1'b0, 16, 1'b0, 1'b0}; // HLOCK after 4 good lines, no vertical lock
    main_tbl[2]  = '{1, 16, 1'b1, 16, 1'b1, 1'b0}; // second VS 10 lines later -> LOCKED
    main_tbl[3]  = '{9, 16, 1'b0, 16, 1'b1, 1'b0}; // full locked frame, visible area checked
    main_tbl[4]  = '{1, 16, 1'b1, 16, 1'b1, 1'b0};
    main_tbl[5]  = '{2, 16, 1'b0, 16, 1'b1, 1'b0};
    main_tbl[6]  = '{1, 15, 1'b0, 16, 1'b1, 1'b0}; // short visible line
    main_tbl[7]  = '{1, 16, 1'b0, 15, 1'b0, 1'b1}; // ERR, unlock, LINE_LEN = 15
    main_tbl[8]  = '{5, 16, 1'b0, 16, 1'b0, 1'b0}; // reacquire horizontally
    main_tbl[9]  = '{1, 16, 1'b1, 16, 1'b1, 1'b0};
    main_tbl[10] = '{7, 16, 1'b0, 16, 1'b1, 1'b0};
    main_tbl[11] = '{1, 16, 1'b1, 16, 1'b0, 1'b1}; // VS after 8 lines -> ERR
    main_tbl[12] = '{9, 16, 1'b0, 16, 1'b0, 1'b0};
    main_tbl[13] = '{1, 16, 1'b1, 16, 1'b1, 1'b0};
    main_tbl[14] = '{2, 16, 1'b0, 16, 1'b1, 1'b0};

    rst_tbl[0] = '{1, 16, 1'b0,  0, 1'b0, 1'b0}; // first edge after reset loads no length
    rst_tbl[1] = '{5, 16, 1'b0, 16, 1'b0, 1'b0};
    rst_tbl[2] = '{1, 16, 1'b1, 16, 1'b0, 1'b0}; // first VS only arms vertical lock
    rst_tbl[3] = '{9, 16, 1'b0, 16, 1'b0, 1'b0};
    rst_tbl[4] = '{1, 16, 1'b1, 16, 1'b1, 1'b0};
    rst_tbl[5] = '{9, 16, 1'b0, 16, 1'b1, 1'b0};

    rst_n = 1'b0;
    hs    = 1'b1;
    vs_in = 1'b1;
    repeat (3) tick();
    chk("reset DE", int'(de), 0);
    chk("reset X", int'(x), 0);
    chk("reset Y", int'(y), 0);
    chk("reset LOCKED", int'(locked), 0);
    chk("reset LINE_LEN", int'(line_len), 0);
    chk("reset ERR", int'(err), 0);
`ifdef VGA_DEC_ERR_CNT_EN
    chk("reset ERR_CNT", int'(err_cnt), 0);
`endif
    rst_n = 1'b1;
    repeat (2) tick();

    foreach (main_tbl[i]) apply_seg(main_tbl[i]);

    // reset in the middle of the first visible line
    for (int c = 0; c < 8; c++) begin
      hs    = (c < H_SYNC) ? 1'b0 : 1'b1;
      vs_in = 1'b1;
      tick();
    end
    chk("pre-reset DE", int'(de), 1);
    chk("pre-reset X", int'(x), 2);
    chk("pre-reset Y", int'(y), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-line reset DE", int'(de), 0);
    chk("mid-line reset X", int'(x), 0);
    chk("mid-line reset Y", int'(y), 0);
    chk("mid-line reset LOCKED", int'(locked), 0);
    chk("mid-line reset LINE_LEN", int'(line_len), 0);
    chk("mid-line reset ERR", int'(err), 0);
    hs    = 1'b1;
    vs_in = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    fl = 3;
    foreach (rst_tbl[i]) apply_seg(rst_tbl[i]);
    chk("pixel queue drained", exp_q.size(), 0);

    // HS stalls high on a locked line: timeout when h_cnt reaches H_TOTAL
    for (int c = 0; c < 40; c++) begin
      hs    = (c < H_SYNC) ? 1'b0 : 1'b1;
      vs_in = (c < H_TOTAL) ? 1'b0 : 1'b1;
      tick();
      if (c == 0) chk("stall edge LOCKED", int'(locked), 1);
      if (c == H_TOTAL - 1) begin
        chk("stall c15 LOCKED", int'(locked), 1);
        chk("stall c15 ERR", int'(err), 0);
      end
      if (c == H_TOTAL) begin
        chk("stall timeout ERR", int'(err), 1);
        chk("stall timeout LOCKED", int'(locked), 0);
      end
      if (c == H_TOTAL + 1) chk("stall ERR one cycle", int'(err), 0);
    end
    chk("stall end LOCKED", int'(locked), 0);
    chk("stall end DE", int'(de), 0);
    chk("stall end LINE_LEN", int'(line_len), 16);
    fl = 0;

`ifdef VGA_DEC_ERR_CNT_EN
    chk("ERR_CNT after stall", int'(err_cnt), 1);
    for (int l = 1; l < V_TOTAL; l++) run_line(16, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    // each frame relocks at VS, then a short line forces one loss of lock
    for (int k = 1; k < 300; k++) begin
      run_line(16, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      run_line(15, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      for (int l = 2; l < V_TOTAL; l++) run_line(16, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      if (k == 10) chk("ERR_CNT after 11 errors", int'(err_cnt), 11);
    end
    chk("ERR_CNT saturated", int'(err_cnt), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
